square_hit_renderer: RTL

Consumer end of the square edge interface (x1/x2/y1/y2 from the bouncing-square animator). Latches the square edges once per frame, draws the square into the VGA pixel stream through a 2-stage pipeline, and re-aligns the syncs to that pipeline. It also counts per-frame overlap between the square and the camera hand mask, and produces a debounced hit pulse and a saturating score. Sits between the display timing generator and the VGA output pins.

---
 rtl/square_hit_renderer_pkg.sv | 16 +
 rtl/square_hit_renderer_inside.sv | 35 +++
 rtl/square_hit_renderer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/square_hit_renderer_pkg.sv
// Shared types and constants for the square renderer and hit scorer.
// Coordinate/colour widths match the 12-bit VGA timing path.
package square_hit_renderer_pkg;

  localparam int COORD_W = 12;
  localparam int RGB_W   = 12;

  localparam logic [RGB_W-1:0] SQ_RGB_DEF  = 12'hF00;
  localparam logic [RGB_W-1:0] HIT_RGB_DEF = 12'h0F0;

  typedef enum logic {
    ARMED    = 1'b0,
    HIT_HOLD = 1'b1
  } hit_state_e;

endpackage

// File: rtl/square_hit_renderer_inside.sv
// Registered point-in-box test with an active qualifier; edges are
// inclusive on x1/y1, exclusive on x2/y2, and an inverted box is empty.
module rect_inside
  import square_hit_renderer_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_x1,
  input  logic [W-1:0] i_x2,
  input  logic [W-1:0] i_y1,
  input  logic [W-1:0] i_y2,
  input  logic         i_active,
  output logic         o_inside
);

  logic in_x;
  logic in_y;

  assign in_x = (i_x >= i_x1) && (i_x < i_x2);
  assign in_y = (i_y >= i_y1) && (i_y < i_y2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_inside <= 1'b0;
    end else if (i_en) begin
      o_inside <= in_x && in_y && i_active;
    end
  end

endmodule

// File: rtl/square_hit_renderer.sv
// Draws the latched square into the pixel stream (2-strobe pipeline) and
// scores per-frame overlap with the hand mask as debounced hits.
module square_hit_renderer
  import square_hit_renderer_pkg::*;
#(
  parameter int               THRESH  = 64,
  parameter logic [RGB_W-1:0] SQ_RGB  = SQ_RGB_DEF,
  parameter logic [RGB_W-1:0] HIT_RGB = HIT_RGB_DEF,
  parameter int               CNT_W   = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_active,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_frame_end,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_x2,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [COORD_W-1:0] i_y2,
  input  logic               i_hand,
  input  logic [RGB_W-1:0]   i_bg_rgb,
  output logic [RGB_W-1:0]   o_rgb,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_hit,
  output logic [7:0]         o_score,
  output logic [CNT_W-1:0]   o_overlap
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != '1)) return c + CNT_W'(1'b1);
    return c;
  endfunction

  function automatic logic [7:0] sat_score(input logic [7:0] s);
    if (s != 8'hFF) return s + 8'd1;
    return s;
  endfunction

  logic [COORD_W-1:0] sx1_q, sx2_q, sy1_q, sy2_q;
  logic               inside_p1, act_p1, hand_p1, hs_p1, vs_p1, fe_p1;
  logic [RGB_W-1:0]   bg_p1;
  logic               ovl_p1;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   total;
  hit_state_e         state_q, state_d;
  logic               hit_d;
  logic [7:0]         score_d;
  logic [RGB_W-1:0]   sq_col;

  // Edges only move at frame end so a square is never torn mid-frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sx1_q <= '0;
      sx2_q <= '0;
      sy1_q <= '0;
      sy2_q <= '0;
    end else if (i_pix_stb && i_frame_end) begin
      sx1_q <= i_x1;
      sx2_q <= i_x2;
      sy1_q <= i_y1;
      sy2_q <= i_y2;
    end
  end

  // ---- stage 1: inside test and aligned side-band ----
  rect_inside #(.W(COORD_W)) u_inside (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_pix_stb),
    .i_x      (i_x),
    .i_y      (i_y),
    .i_x1     (sx1_q),
    .i_x2     (sx2_q),
    .i_y1     (sy1_q),
    .i_y2     (sy2_q),
    .i_active (i_active),
    .o_inside (inside_p1)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_p1  <= 1'b0;
      hand_p1 <= 1'b0;
      bg_p1   <= '0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
      fe_p1   <= 1'b0;
    end else if (i_pix_stb) begin
      act_p1  <= i_active;
      hand_p1 <= i_hand;
      bg_p1   <= i_bg_rgb;
      hs_p1   <= i_hsync;
      vs_p1   <= i_vsync;
      fe_p1   <= i_frame_end;
    end
  end

  // inside_p1 already carries the active qualifier.
  assign ovl_p1 = hand_p1 & inside_p1;
  assign sq_col = (state_q == HIT_HOLD) ? HIT_RGB : SQ_RGB;

  // ---- stage 2: colour mux and sync re-alignment ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rgb   <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else if (i_pix_stb) begin
      o_rgb   <= !act_p1 ? '0 : (inside_p1 ? sq_col : bg_p1);
      o_hsync <= hs_p1;
      o_vsync <= vs_p1;
    end
  end

  // The pixel that coincides with frame end still counts into its frame.
  assign total = sat_cnt(cnt_q, ovl_p1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      o_overlap <= '0;
    end else if (i_pix_stb) begin
      if (fe_p1) begin
        cnt_q     <= '0;
        o_overlap <= total;
      end else begin
        cnt_q <= total;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    score_d = o_score;
    if (i_pix_stb && fe_p1) begin
      case (state_q)
        ARMED: begin
          if (total >= THRESH_C) begin
            state_d = HIT_HOLD;
            hit_d   = 1'b1;
            score_d = sat_score(o_score);
          end
        end
        HIT_HOLD: begin
          if (total < THRESH_C) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // o_hit is rewritten every clock, so a pulse lasts exactly one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARMED;
      o_hit   <= 1'b0;
      o_score <= '0;
    end else begin
      state_q <= state_d;
      o_hit   <= hit_d;
      o_score <= score_d;
    end
  end

endmodule
